// File: rtl/sha3_sponge_ctrl_pkg.sv
// rtl/sha3_sponge_ctrl_pkg.sv - shared types for the SHA3 sponge controller
package sha3_sponge_ctrl_pkg;

    // Pairwise Hamming distance >= 3, so a single upset never forms another legal state.
    typedef enum logic [5:0] {
        StIdle      = 6'b000111,
        StAbsorb    = 6'b011001,
        StSqueeze   = 6'b101010,
        StManualRun = 6'b110100,
        StFlush     = 6'b111111,
        StError     = 6'b000000
    } ctrl_st_e;

    typedef enum logic [7:0] {
        ErrNone          = 8'h00,
        ErrSha3SwControl = 8'h05,
        ErrSha3Timeout   = 8'h0a,
        ErrSha3FsmState  = 8'h0b
    } err_code_e;

    typedef struct packed {
        logic        valid;
        err_code_e   code;
        logic [23:0] info;
    } err_t;

    typedef enum logic [3:0] {
        MuxGuard   = 4'b0101,
        MuxRelease = 4'b1010
    } mux_sel_e;

    localparam logic [23:0] InfoBudget = 24'h000010;

endpackage

// File: rtl/sha3_sponge_ctrl_state_guard.sv
// rtl/sha3_sponge_ctrl_state_guard.sv - releases Keccak state shares only on the release select
module sha3_sponge_ctrl_state_guard
    import sha3_sponge_ctrl_pkg::*;
#(
    parameter int StateW = 1600,
    parameter int Share  = 1
) (
    input  mux_sel_e          i_mux_sel,
    input  logic [StateW-1:0] i_state [Share],
    output logic [StateW-1:0] o_state [Share]
);

    always_comb begin
        for (int s = 0; s < Share; s++) begin
            o_state[s] = (i_mux_sel == MuxRelease) ? i_state[s] : '0;
        end
    end

endmodule

// File: rtl/sha3_sponge_ctrl.sv
// rtl/sha3_sponge_ctrl.sv - SHA3 sponge sequencer with block budget, watchdog and error state
module sha3_sponge_ctrl
    import sha3_sponge_ctrl_pkg::*;
#(
    parameter bit  EnMasking     = 1'b0,
    parameter int  StateW        = 1600,
    parameter int  MaxBlocks     = 16,
    parameter int  TimeoutCycles = 255,
    localparam int Share         = EnMasking ? 2 : 1,
    localparam int BlkW          = $clog2(MaxBlocks + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              process_i,
    input  logic              run_i,
    input  logic              done_i,
    input  logic              abort_i,
    input  logic [BlkW-1:0]   blocks_i,
    input  logic              absorbed_i,
    input  logic              keccak_complete_i,
    input  logic [StateW-1:0] state_i [Share],
    output logic              keccak_start_o,
    output logic              keccak_process_o,
    output logic              keccak_run_o,
    output logic              keccak_clear_o,
    output logic              absorbed_o,
    output logic              squeezing_o,
    output logic              state_valid_o,
    output logic [StateW-1:0] state_o [Share],
    output logic [BlkW-1:0]   blocks_left_o,
    output ctrl_st_e          fsm_o,
    output err_t              error_o
);

    localparam int WdW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

    ctrl_st_e        r_st;
    logic            r_processing;
    logic [BlkW-1:0] r_blocks;
    logic [WdW-1:0]  r_wdog;
    logic            r_absorbed;

    ctrl_st_e        w_st_next;
    logic            w_set_proc, w_load_blocks, w_dec_blocks, w_waiting, w_expire, w_sw_err;
    logic [BlkW-1:0] w_blocks_init;
    logic [23:0]     w_info, w_info_extra;
    err_t            w_err;
    mux_sel_e        w_mux_sel;

    assign w_info    = 24'({abort_i, done_i, run_i, process_i, start_i});
    assign w_waiting = (r_st == StManualRun) || ((r_st == StAbsorb) && r_processing);
    // Expires during the TimeoutCycles-th waiting cycle, counting the entry cycle as the first.
    assign w_expire  = (TimeoutCycles != 0) && w_waiting && (int'(r_wdog) + 1 == TimeoutCycles);

    always_comb begin
        if (blocks_i == '0)                     w_blocks_init = BlkW'(1);
        else if (blocks_i > BlkW'(MaxBlocks))   w_blocks_init = BlkW'(MaxBlocks);
        else                                    w_blocks_init = blocks_i;
    end

    always_comb begin
        w_st_next        = r_st;
        keccak_start_o   = 1'b0;
        keccak_process_o = 1'b0;
        keccak_run_o     = 1'b0;
        keccak_clear_o   = 1'b0;
        w_set_proc       = 1'b0;
        w_load_blocks    = 1'b0;
        w_dec_blocks     = 1'b0;
        w_sw_err         = 1'b0;
        w_info_extra     = '0;
        w_err            = '{valid: 1'b0, code: ErrNone, info: 24'h0};
        case (r_st)
            StIdle: begin
                if (start_i) begin
                    w_st_next      = StAbsorb;
                    keccak_start_o = 1'b1;
                    w_load_blocks  = 1'b1;
                end
                w_sw_err = process_i || run_i || done_i;
            end
            StAbsorb: begin
                if (abort_i) begin
                    w_st_next      = StFlush;
                    keccak_clear_o = 1'b1;
                end else if (w_expire) begin
                    w_st_next = StError;
                    w_err     = '{valid: 1'b1, code: ErrSha3Timeout, info: w_info};
                end else begin
                    if (process_i && !r_processing) begin
                        keccak_process_o = 1'b1;
                        w_set_proc       = 1'b1;
                    end
                    if (absorbed_i) w_st_next = StSqueeze;
                    w_sw_err = start_i || run_i || done_i || (process_i && r_processing);
                end
            end
            StSqueeze: begin
                if (abort_i) begin
                    w_st_next      = StFlush;
                    keccak_clear_o = 1'b1;
                end else begin
                    if (run_i) begin
                        if (r_blocks > BlkW'(1)) begin
                            w_st_next    = StManualRun;
                            keccak_run_o = 1'b1;
                            w_dec_blocks = 1'b1;
                        end else begin
                            w_sw_err     = 1'b1;
                            w_info_extra = InfoBudget;
                        end
                    end else if (done_i) begin
                        w_st_next      = StFlush;
                        keccak_clear_o = 1'b1;
                    end
                    if (start_i || process_i) w_sw_err = 1'b1;
                end
            end
            StManualRun: begin
                if (abort_i) begin
                    w_st_next      = StFlush;
                    keccak_clear_o = 1'b1;
                end else if (w_expire) begin
                    w_st_next = StError;
                    w_err     = '{valid: 1'b1, code: ErrSha3Timeout, info: w_info};
                end else begin
                    if (keccak_complete_i) w_st_next = StSqueeze;
                    w_sw_err = start_i || process_i || run_i;
                end
            end
            StFlush: begin
                w_st_next = StIdle;
                w_sw_err  = start_i || process_i || run_i;
            end
            StError: begin
                if (done_i || abort_i) begin
                    w_st_next      = StFlush;
                    keccak_clear_o = 1'b1;
                end
                w_sw_err = start_i || process_i || run_i;
            end
            default: begin
                w_st_next = StError;
                w_err     = '{valid: 1'b1, code: ErrSha3FsmState, info: w_info};
            end
        endcase
        if (w_sw_err) w_err = '{valid: 1'b1, code: ErrSha3SwControl, info: w_info | w_info_extra};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st         <= StIdle;
            r_processing <= 1'b0;
            r_blocks     <= '0;
            r_wdog       <= '0;
            r_absorbed   <= 1'b0;
        end else begin
            r_st         <= w_st_next;
            r_absorbed   <= absorbed_i;
            r_processing <= (w_st_next == StAbsorb) && (r_processing || w_set_proc);
            if (w_load_blocks)          r_blocks <= w_blocks_init;
            else if (w_dec_blocks)      r_blocks <= r_blocks - BlkW'(1);
            else if (r_st == StFlush)   r_blocks <= '0;
            r_wdog <= ((TimeoutCycles != 0) && w_waiting && (w_st_next == r_st)) ?
                      r_wdog + WdW'(1) : '0;
        end
    end

    assign w_mux_sel     = (r_st == StSqueeze) ? MuxRelease : MuxGuard;
    assign squeezing_o   = (r_st == StSqueeze);
    assign state_valid_o = (r_st == StSqueeze);
    assign absorbed_o    = r_absorbed;
    assign blocks_left_o = r_blocks;
    assign fsm_o         = r_st;
    assign error_o       = w_err;

    sha3_sponge_ctrl_state_guard #(
        .StateW (StateW),
        .Share  (Share)
    ) u_state_guard (
        .i_mux_sel (w_mux_sel),
        .i_state   (state_i),
        .o_state   (state_o)
    );

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// tb/tb_sha3_sponge_ctrl.sv - self-checking bench for the SHA3 sponge controller
module tb_sha3_sponge_ctrl;
    import sha3_sponge_ctrl_pkg::*;

    localparam int SW = 64;
    localparam int MB = 16;
    localparam int TO = 8;
    localparam logic [4:0] C_NONE = 5'b00000, C_START = 5'b00001, C_PROC = 5'b00010,
                           C_RUN = 5'b00100, C_DONE = 5'b01000, C_ABORT = 5'b10000;

    logic          clk_i = 1'b0, rst_i = 1'b1;
    logic          start_i = 0, process_i = 0, run_i = 0, done_i = 0, abort_i = 0;
    logic [4:0]    blocks_i = '0;
    logic          absorbed_i = 0, keccak_complete_i = 0;
    logic [SW-1:0] state_i [2];
    logic          keccak_start_o, keccak_process_o, keccak_run_o, keccak_clear_o;
    logic          absorbed_o, squeezing_o, state_valid_o;
    logic [SW-1:0] state_o [2];
    logic [4:0]    blocks_left_o;
    ctrl_st_e      fsm_o;
    err_t          error_o;

    int checks = 0, failures = 0;
    logic [SW-1:0] sd0, sd1;
    int b, exp_left, runs, waits;

    sha3_sponge_ctrl #(
        .EnMasking(1'b1), .StateW(SW), .MaxBlocks(MB), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .process_i(process_i),
        .run_i(run_i), .done_i(done_i), .abort_i(abort_i), .blocks_i(blocks_i),
        .absorbed_i(absorbed_i), .keccak_complete_i(keccak_complete_i), .state_i(state_i),
        .keccak_start_o(keccak_start_o), .keccak_process_o(keccak_process_o),
        .keccak_run_o(keccak_run_o), .keccak_clear_o(keccak_clear_o),
        .absorbed_o(absorbed_o), .squeezing_o(squeezing_o), .state_valid_o(state_valid_o),
        .state_o(state_o), .blocks_left_o(blocks_left_o), .fsm_o(fsm_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] cmd);
        {abort_i, done_i, run_i, process_i, start_i} = cmd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        {abort_i, done_i, run_i, process_i, start_i} = C_NONE;
        absorbed_i = 1'b0;
        keccak_complete_i = 1'b0;
    endtask

    task automatic new_state();
        sd0 = {$urandom, $urandom};
        sd1 = {$urandom, $urandom};
        state_i[0] = sd0;
        state_i[1] = sd1;
    endtask

    task automatic go_squeeze(input int blk, input int exp_blk);
        blocks_i = 5'(blk);
        drive(C_START);
        chk("start_pulse", 64'(keccak_start_o), 64'd1);
        tick();
        chk("absorb_guard", state_o[0], 64'd0);
        drive(C_PROC);
        chk("process_pulse", 64'(keccak_process_o), 64'd1);
        tick();
        absorbed_i = 1'b1;
        drive(C_NONE);
        tick();
        chk("fsm_squeeze", 64'(fsm_o), 64'(StSqueeze));
        chk("blocks_loaded", 64'(blocks_left_o), 64'(exp_blk));
        chk("state_rel0", state_o[0], sd0);
        chk("state_rel1", state_o[1], sd1);
    endtask

    task automatic finish_flush(input logic [4:0] cmd);
        drive(cmd);
        chk("clear_pulse", 64'(keccak_clear_o), 64'd1);
        tick();
        chk("fsm_flush", 64'(fsm_o), 64'(StFlush));
        chk("flush_guard", state_o[0], 64'd0);
        tick();
        chk("fsm_idle", 64'(fsm_o), 64'(StIdle));
        chk("blocks_zero", 64'(blocks_left_o), 64'd0);
    endtask

    initial begin
        new_state();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("rst_fsm", 64'(fsm_o), 64'(StIdle));
        chk("rst_blocks", 64'(blocks_left_o), 64'd0);
        chk("rst_absorbed", 64'(absorbed_o), 64'd0);
        chk("rst_state", state_o[0], 64'd0);
        chk("rst_pulses", 64'({keccak_start_o, keccak_process_o, keccak_run_o, keccak_clear_o}), 64'd0);
        chk("rst_err", 64'(error_o.valid), 64'd0);
        rst_i = 1'b0;
        tick();

        // Illegal command in idle, and abort in idle is silently ignored.
        drive(C_RUN);
        chk("idle_run_err", 64'(error_o.valid), 64'd1);
        chk("idle_run_info", 64'(error_o.info), 64'h04);
        chk("idle_run_nopulse", 64'(keccak_run_o), 64'd0);
        tick();
        drive(C_ABORT);
        chk("idle_abort_noerr", 64'(error_o.valid), 64'd0);
        tick();
        chk("idle_abort_stay", 64'(fsm_o), 64'(StIdle));

        // Directed: blocks=3, repeated process, two runs, budget exhaustion.
        new_state();
        blocks_i = 5'd3;
        drive(C_START);
        tick();
        drive(C_PROC);
        chk("a_proc1", 64'(keccak_process_o), 64'd1);
        tick();
        drive(C_PROC);
        chk("a_proc2_nopulse", 64'(keccak_process_o), 64'd0);
        chk("a_proc2_err", 64'(error_o.valid), 64'd1);
        chk("a_proc2_code", 64'(error_o.code), 64'(ErrSha3SwControl));
        chk("a_proc2_info", 64'(error_o.info), 64'h02);
        tick();
        absorbed_i = 1'b1;
        drive(C_NONE);
        chk("a_not_valid_yet", 64'(state_valid_o), 64'd0);
        tick();
        chk("a_fsm_sq", 64'(fsm_o), 64'(StSqueeze));
        chk("a_valid", 64'(state_valid_o), 64'd1);
        chk("a_squeezing", 64'(squeezing_o), 64'd1);
        chk("a_blocks3", 64'(blocks_left_o), 64'd3);
        chk("a_absorbed_o", 64'(absorbed_o), 64'd1);
        chk("a_state1", state_o[1], sd1);
        for (int r = 0; r < 2; r++) begin
            drive(C_RUN);
            chk("a_run_pulse", 64'(keccak_run_o), 64'd1);
            tick();
            chk("a_fsm_run", 64'(fsm_o), 64'(StManualRun));
            chk("a_run_guard", state_o[0], 64'd0);
            chk("a_blocks_dec", 64'(blocks_left_o), 64'(2 - r));
            keccak_complete_i = 1'b1;
            drive(C_NONE);
            tick();
            chk("a_back_sq", 64'(fsm_o), 64'(StSqueeze));
        end
        drive(C_RUN);
        chk("a_budget_nopulse", 64'(keccak_run_o), 64'd0);
        chk("a_budget_err", 64'(error_o.valid), 64'd1);
        chk("a_budget_info", 64'(error_o.info), 64'h14);
        tick();
        chk("a_budget_stay", 64'(fsm_o), 64'(StSqueeze));
        finish_flush(C_DONE);

        // Randomized hashes checked against block-budget arithmetic.
        for (int it = 0; it < 8; it++) begin
            b = (it == 0) ? 0 : (it == 1) ? 31 : int'($urandom_range(0, 31));
            exp_left = (b == 0) ? 1 : (b > MB) ? MB : b;
            new_state();
            go_squeeze(b, exp_left);
            runs = int'($urandom_range(0, exp_left));
            for (int r = 0; r < runs; r++) begin
                drive(C_RUN);
                if (exp_left > 1) begin
                    chk("r_run_pulse", 64'(keccak_run_o), 64'd1);
                    tick();
                    exp_left--;
                    chk("r_blocks", 64'(blocks_left_o), 64'(exp_left));
                    waits = int'($urandom_range(0, 3));
                    for (int w = 0; w < waits; w++) begin
                        drive(C_NONE);
                        chk("r_wait_run", 64'(fsm_o), 64'(StManualRun));
                        tick();
                    end
                    keccak_complete_i = 1'b1;
                    drive(C_NONE);
                    tick();
                    chk("r_back_sq", 64'(fsm_o), 64'(StSqueeze));
                    chk("r_state0", state_o[0], sd0);
                end else begin
                    chk("r_budget_nopulse", 64'(keccak_run_o), 64'd0);
                    chk("r_budget_info", 64'(error_o.info), 64'h14);
                    tick();
                end
            end
            finish_flush(($urandom_range(0, 1) == 0) ? C_DONE : C_ABORT);
        end

        // Abort during a permutation.
        new_state();
        go_squeeze(4, 4);
        drive(C_RUN);
        tick();
        chk("ab_fsm_run", 64'(fsm_o), 64'(StManualRun));
        drive(C_ABORT);
        chk("ab_noerr", 64'(error_o.valid), 64'd0);
        finish_flush(C_ABORT);

        // Watchdog: no keccak completion.
        new_state();
        go_squeeze(2, 2);
        drive(C_RUN);
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            drive(C_NONE);
            chk("to_wait_noerr", 64'(error_o.valid), 64'd0);
            chk("to_wait_fsm", 64'(fsm_o), 64'(StManualRun));
            tick();
        end
        drive(C_NONE);
        chk("to_err_valid", 64'(error_o.valid), 64'd1);
        chk("to_err_code", 64'(error_o.code), 64'(ErrSha3Timeout));
        tick();
        chk("to_fsm_err", 64'(fsm_o), 64'(StError));
        chk("to_guard", state_o[0], 64'd0);
        chk("to_not_valid", 64'(state_valid_o), 64'd0);
        drive(C_RUN);
        chk("to_run_nopulse", 64'(keccak_run_o), 64'd0);
        chk("to_run_err", 64'(error_o.code), 64'(ErrSha3SwControl));
        tick();
        finish_flush(C_DONE);

        // Reset asserted while squeezing.
        new_state();
        go_squeeze(5, 5);
        absorbed_i = 1'b1;
        drive(C_NONE);
        tick();
        chk("rs_absorbed_hi", 64'(absorbed_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("rs_fsm", 64'(fsm_o), 64'(StIdle));
        chk("rs_state", state_o[0], 64'd0);
        chk("rs_valid", 64'(state_valid_o), 64'd0);
        chk("rs_absorbed", 64'(absorbed_o), 64'd0);
        chk("rs_blocks", 64'(blocks_left_o), 64'd0);
        tick();
        rst_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
